// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory bus between the IF-stage fetch port and the MEM-stage
//   load/store port. The data port has fixed priority, so the older pipeline
//   instruction drains first. One bus transaction is outstanding at a time,
//   and its response is steered back to the port that owns it.
//
//   Ports
//     clk_i, rst_ni          core clock, asynchronous active-low reset
//     instr_*                fetch port: req/addr/flush in, gnt/rvalid/rdata out
//     data_*                 load/store port: req/we/wmask/addr/wdata in,
//                            gnt/rvalid/rdata out
//     mem_*                  bus side: req/we/wmask/addr/wdata out,
//                            gnt/rvalid/rdata in
//
//   Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
//   data grants made while a fetch waits, the next arbitration goes to the
//   fetch. Without the macro, data priority is strict.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_flush_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_wmask_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_wmask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

  state_t state_q;
  owner_t owner_q;
  logic   drop_q;
  logic   in_idle;
  logic   data_win;
  logic   instr_win;
  logic   resp_fire;
  logic   force_instr;

  assign in_idle = (state_q == S_IDLE);

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  // A flushed fetch cannot be granted, so it cannot claim the forced slot.
  assign force_instr = (starve_q == 4'(STARVE_LIMIT)) && instr_req_i && !instr_flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (in_idle) begin
      if (instr_win || !instr_req_i) begin
        starve_q <= '0;
      end else if (data_win && starve_q != 4'hF) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`else
  assign force_instr = 1'b0;
`endif

  // Arbitration is combinational and only in IDLE; grants pulse this cycle.
  assign data_win    = in_idle && data_req_i && !force_instr;
  assign instr_win   = in_idle && instr_req_i && !instr_flush_i && !data_win;
  assign data_gnt_o  = data_win;
  assign instr_gnt_o = instr_win;

  // Responses outside RESP are protocol errors and are dropped here.
  assign resp_fire      = (state_q == S_RESP) && mem_rvalid_i;
  assign instr_rvalid_o = resp_fire && (owner_q == OWN_INSTR) && !drop_q && !instr_flush_i;
  assign data_rvalid_o  = resp_fire && (owner_q == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

  assign mem_req_o = (state_q == S_REQ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_INSTR;
      drop_q      <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_wmask_o <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          drop_q <= 1'b0;
          if (data_win) begin
            owner_q     <= OWN_DATA;
            mem_we_o    <= data_we_i;
            mem_wmask_o <= data_wmask_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
            state_q     <= S_REQ;
          end else if (instr_win) begin
            owner_q     <= OWN_INSTR;
            mem_we_o    <= 1'b0;
            mem_wmask_o <= '0;
            mem_addr_o  <= instr_addr_i;
            mem_wdata_o <= '0;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (instr_flush_i && owner_q == OWN_INSTR) drop_q <= 1'b1;
          if (mem_gnt_i) state_q <= S_RESP;
        end
        S_RESP: begin
          if (instr_flush_i && owner_q == OWN_INSTR) drop_q <= 1'b1;
          if (mem_rvalid_i) begin
            drop_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory bus between the IF stage instruction-fetch port and the MEM stage load/store port.
- The data port has fixed priority, because the older instruction in the pipeline must drain first.
- One transaction is outstanding at a time.
- The response is routed back to the requester that owns the transaction.
- Sits between the pipeline memory ports and the external memory/bus adapter.

Parameters:
- ADDR_W, 32: address width of every port.
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits. Used only with the optional feature; legal range 1..15.

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request; instr_addr_i held until instr_gnt_o
instr_addr_i  in  ADDR_W  fetch address
instr_flush_i  in  1  IF flush; drop pending fetch response
instr_gnt_o  out  1  fetch accepted (1-cycle pulse)
instr_rvalid_o  out  1  fetch response valid (1-cycle pulse)
instr_rdata_o  out  32  fetch data; 0 when instr_rvalid_o low
data_req_i  in  1  load/store request; fields held until data_gnt_o
data_we_i  in  1  1 = store
data_wmask_i  in  4  store byte mask
data_addr_i  in  ADDR_W  data address
data_wdata_i  in  32  store data, already lane-aligned
data_gnt_o  out  1  data accepted (1-cycle pulse)
data_rvalid_o  out  1  data response valid, for loads and stores (1-cycle pulse)
data_rdata_o  out  32  load data; 0 when data_rvalid_o low
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write enable
mem_wmask_o  out  4  bus byte mask
mem_addr_o  out  ADDR_W  bus address
mem_wdata_o  out  32  bus write data
mem_gnt_i  in  1  bus accepted request
mem_rvalid_i  in  1  bus response valid
mem_rdata_i  in  32  bus read data

Behaviour:
- State machine states:
  - IDLE: mem_req_o = 0.
  - REQ: mem_req_o = 1; drives the latched fields.
  - RESP: mem_req_o = 0; waits for mem_rvalid_i.
- Owner register: owner_q (INSTR/DATA). Drop register: drop_q.
- Arbitration happens in IDLE only and is combinational:
  - data_req_i = 1 wins; otherwise instr_req_i wins.
  - The winner's gnt_o is pulsed in that same cycle.
  - At the edge, the winner's fields are latched into the mem_* registers and the state moves IDLE -> REQ.
- Fetch transaction fields: mem_we_o = 0, mem_wmask_o = 0, mem_wdata_o = 0.
- REQ -> RESP on mem_gnt_i = 1. The mem_* fields stay stable until the grant.
- RESP -> IDLE on mem_rvalid_i = 1:
  - owner's rvalid_o = 1 and rdata_o = mem_rdata_i, combinationally in the same cycle;
  - for a store, data_rdata_o = mem_rdata_i is don't-care; the bench checks only data_rvalid_o.
- Minimum timing, request seen at cycle N:
  - gnt at N;
  - mem_req_o at N+1; mem_gnt_i may arrive at N+1;
  - earliest rvalid_o at N+2;
  - next arbitration at N+3.
- Because the next arbitration is at N+3, back-to-back throughput is one transaction per 3 cycles at minimum.
- mem_rvalid_i while in IDLE or REQ is a protocol error: ignored, and no rvalid_o is produced.
- instr_flush_i:
  - If asserted in REQ or RESP while owner_q = INSTR, set drop_q. The bus transaction still completes; it is never retracted.
  - The matching response produces no instr_rvalid_o; drop_q clears on return to IDLE.
  - If asserted in IDLE, it suppresses instr_gnt_o that cycle; a data request may still win.
  - If asserted in the same cycle as the final mem_rvalid_i of an INSTR transaction, instr_rvalid_o is suppressed.
- Simultaneous data_req_i and instr_req_i in IDLE: data is granted and the fetch keeps waiting.
- Reset (async assert, sync-safe deassert):
  - state = IDLE; owner_q = INSTR; drop_q = 0;
  - all mem_* outputs = 0; all gnt_o/rvalid_o = 0.
- Reset mid-transaction abandons it; a late mem_rvalid_i after reset is ignored (IDLE rule).

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - 4-bit counter starve_q counts data grants made while instr_req_i = 1.
  - When starve_q == STARVE_LIMIT, the next arbitration grants the fetch even if data_req_i = 1.
  - starve_q clears on any fetch grant, on an arbitration with instr_req_i = 0, and on reset.
- Undefined: strict data priority and no counter.

Test Plan:
- Fetch only: instr_req_i=1, addr 0x100; bus gnt at N+1, rvalid at N+2 with rdata 0x00000013 -> instr_gnt_o at N, mem_addr_o=0x100, mem_we_o=0, instr_rvalid_o at N+2 with 0x00000013.
- Simultaneous requests: data SW to addr 0x2000, wmask 0xF, wdata 0xDEADBEEF, plus fetch to 0x104 -> data granted first and the bus sees the store; fetch granted at the next IDLE; each rvalid goes only to its owner.
- Bus stall: mem_gnt_i low for 5 cycles -> mem_req_o and mem_addr_o stay stable; no response before the grant.
- Flush: flush while a fetch sits in RESP; rvalid arrives 3 cycles later -> no instr_rvalid_o; the next request is arbitrated normally.
- Reset in RESP: rst_ni low for 1 cycle, then a stray mem_rvalid_i -> all outputs 0 and no rvalid_o.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4: data_req_i and instr_req_i held high -> 4 data grants, then 1 fetch grant, repeating.
